pc_out_wrr_merge: RTL and testbench

- Replaces the fair two-input channel merge in front of the PC-bound stream.
- Arbitrates between core-generated PC traffic (source 0) and tagged BD_out traffic (source 1) onto one PC_out word stream.
- Uses weighted round-robin with runtime-configurable burst weights, a registered output stage, and per-source word counters for host diagnostics.

---
 rtl/pc_out_wrr_merge_pkg.sv | 13 +
 rtl/pc_out_wrr_merge_wrr_grant.sv | 46 ++++
 rtl/pc_out_wrr_merge.sv | 110 +++++++++++
 tb/tb_pc_out_wrr_merge.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_out_wrr_merge_pkg.sv
// Shared types and constants for the PC_out weighted round-robin merge.
package pc_out_wrr_merge_pkg;

  localparam int PC_WORD_W       = 32;
  localparam int DEF_WEIGHT_CORE = 4;
  localparam int DEF_WEIGHT_BD   = 4;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } owner_e;

endpackage

// File: rtl/pc_out_wrr_merge_wrr_grant.sv
// Combinational weighted round-robin grant between core (SRC0) and BD (SRC1) sources.
// Zero-latency decision; the caller qualifies the grant with output-register space.
module wrr_grant
  import pc_out_wrr_merge_pkg::*;
#(
  parameter int NWeight = 4
) (
  input  owner_e               owner_i,
  input  logic [NWeight-1:0]   cred_i,
  input  logic [NWeight-1:0]   weight0_i,
  input  logic [NWeight-1:0]   weight1_i,
  input  logic                 in0_v_i,
  input  logic                 in1_v_i,
  output logic                 gnt_vld_o,
  output owner_e               gnt_src_o,
  output logic [NWeight-1:0]   own_weff_o
);

  logic [NWeight-1:0] weff0;
  logic [NWeight-1:0] weff1;
  logic               own_v;
  logic               oth_v;
  owner_e             other;

  // A zero weight still lets the owner send one word per tenure.
  assign weff0      = (weight0_i == '0) ? NWeight'(1) : weight0_i;
  assign weff1      = (weight1_i == '0) ? NWeight'(1) : weight1_i;
  assign own_weff_o = (owner_i == SRC0) ? weff0 : weff1;
  assign own_v      = (owner_i == SRC0) ? in0_v_i : in1_v_i;
  assign oth_v      = (owner_i == SRC0) ? in1_v_i : in0_v_i;
  assign other      = (owner_i == SRC0) ? SRC1 : SRC0;

  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_src_o = owner_i;
    if (own_v && (cred_i < own_weff_o)) begin
      gnt_vld_o = 1'b1;
    end else if (oth_v) begin
      gnt_vld_o = 1'b1;
      gnt_src_o = other;
    end else if (own_v) begin
      gnt_vld_o = 1'b1;
    end
  end

endmodule

// File: rtl/pc_out_wrr_merge.sv
// Merges core PC traffic and BD_out traffic onto PC_out by weighted round-robin.
// One-cycle accept-to-out_v latency; a stalled output register blocks both inputs.
module pc_out_wrr_merge
  import pc_out_wrr_merge_pkg::*;
#(
  parameter int NWord   = PC_WORD_W,
  parameter int NWeight = 4,
  parameter int NCount  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in0_v,
  input  logic [NWord-1:0]   in0_d,
  output logic               in0_a,
  input  logic               in1_v,
  input  logic [NWord-1:0]   in1_d,
  output logic               in1_a,
  output logic               out_v,
  output logic [NWord-1:0]   out_d,
  input  logic               out_a,
  input  logic [NWeight-1:0] weight0,
  input  logic [NWeight-1:0] weight1,
  input  logic               cnt_clear,
  output logic [NCount-1:0]  cnt0,
  output logic [NCount-1:0]  cnt1
);

  logic               out_v_q;
  logic [NWord-1:0]   out_d_q;
  owner_e             owner_q, owner_d;
  logic [NWeight-1:0] cred_q, cred_d;
  logic [NCount-1:0]  cnt0_q, cnt1_q;

  logic               load_ok;
  logic               gnt_vld;
  owner_e             gnt_src;
  logic [NWeight-1:0] own_weff;
  logic               xfer;

  wrr_grant #(
    .NWeight (NWeight)
  ) u_grant (
    .owner_i    (owner_q),
    .cred_i     (cred_q),
    .weight0_i  (weight0),
    .weight1_i  (weight1),
    .in0_v_i    (in0_v),
    .in1_v_i    (in1_v),
    .gnt_vld_o  (gnt_vld),
    .gnt_src_o  (gnt_src),
    .own_weff_o (own_weff)
  );

  assign load_ok = !out_v_q || out_a;
  // Accepts are masked while reset is held so nothing is counted or captured.
  assign in0_a   = reset && load_ok && gnt_vld && (gnt_src == SRC0);
  assign in1_a   = reset && load_ok && gnt_vld && (gnt_src == SRC1);
  assign xfer    = in0_a || in1_a;

  always_comb begin
    owner_d = owner_q;
    cred_d  = cred_q;
    if (xfer) begin
      if (gnt_src == owner_q) begin
        cred_d = (cred_q < own_weff) ? cred_q + NWeight'(1) : own_weff;
      end else begin
        owner_d = gnt_src;
        cred_d  = NWeight'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_v_q <= 1'b0;
      out_d_q <= '0;
      owner_q <= SRC0;
      cred_q  <= '0;
    end else begin
      owner_q <= owner_d;
      cred_q  <= cred_d;
      if (xfer) begin
        out_v_q <= 1'b1;
        out_d_q <= (gnt_src == SRC0) ? in0_d : in1_d;
      end else if (out_a) begin
        out_v_q <= 1'b0;
      end
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (cnt_clear) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (in0_a) cnt0_q <= cnt0_q + NCount'(1);
      if (in1_a) cnt1_q <= cnt1_q + NCount'(1);
    end
  end

  assign out_v = out_v_q;
  assign out_d = out_d_q;
  assign cnt0  = cnt0_q;
  assign cnt1  = cnt1_q;

endmodule

// File: tb/tb_pc_out_wrr_merge.sv
// Self-checking bench for pc_out_wrr_merge: vector table, directed corner sequences, random vs reference model.
module tb_pc_out_wrr_merge;

  logic        clk = 1'b0;
  logic        reset;
  logic        in0_v, in1_v, in0_a, in1_a;
  logic [31:0] in0_d, in1_d;
  logic        out_v, out_a;
  logic [31:0] out_d;
  logic [3:0]  weight0, weight1;
  logic        cnt_clear;
  logic [15:0] cnt0, cnt1;

  pc_out_wrr_merge dut (
    .clk       (clk),
    .reset     (reset),
    .in0_v     (in0_v),
    .in0_d     (in0_d),
    .in0_a     (in0_a),
    .in1_v     (in1_v),
    .in1_d     (in1_d),
    .in1_a     (in1_a),
    .out_v     (out_v),
    .out_d     (out_d),
    .out_a     (out_a),
    .weight0   (weight0),
    .weight1   (weight1),
    .cnt_clear (cnt_clear),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the link, words used this tenure, counters, words in flight.
  int          m_owner, m_used, m_cnt0, m_cnt1;
  logic        m_out_v;
  logic [31:0] sb[$];

  // DUT values sampled during the most recent step.
  logic        s_a0, s_a1, s_ov;
  logic [31:0] s_od;

  typedef struct {
    logic       v0, v1;
    logic [3:0] w0, w1;
    logic       oa;
    logic       ea0, ea1, eov;
  } vec_t;
  vec_t tbl[12];

  logic [31:0] hold_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: inputs were set after the falling edge; compare, then advance model.
  task automatic step();
    int g, o, vo, vx, wo, weff0, weff1;
    logic lok;
    #1;
    if (!reset) begin
      m_out_v = 1'b0; m_owner = 0; m_used = 0; m_cnt0 = 0; m_cnt1 = 0;
      sb.delete();
    end
    weff0 = (weight0 == 4'd0) ? 1 : int'(weight0);
    weff1 = (weight1 == 4'd0) ? 1 : int'(weight1);
    o  = m_owner;
    vo = (o == 0) ? int'(in0_v) : int'(in1_v);
    vx = (o == 0) ? int'(in1_v) : int'(in0_v);
    wo = (o == 0) ? weff0 : weff1;
    lok = !m_out_v || out_a;
    g = -1;
    if (vo != 0 && m_used < wo) g = o;
    else if (vx != 0)           g = 1 - o;
    else if (vo != 0)           g = o;
    if (!reset || !lok) g = -1;

    s_a0 = in0_a; s_a1 = in1_a; s_ov = out_v; s_od = out_d;
    chk("in0_a", 32'(in0_a), 32'(g == 0));
    chk("in1_a", 32'(in1_a), 32'(g == 1));
    chk("out_v", 32'(out_v), 32'(m_out_v));
    if (m_out_v && sb.size() > 0) chk("out_d", out_d, sb[0]);
    chk("cnt0", 32'(cnt0), 32'(m_cnt0));
    chk("cnt1", 32'(cnt1), 32'(m_cnt1));

    @(posedge clk);
    if (reset) begin
      if (m_out_v && out_a && sb.size() > 0) void'(sb.pop_front());
      if (g >= 0) begin
        sb.push_back((g == 0) ? in0_d : in1_d);
        m_out_v = 1'b1;
        if (g == o) m_used = (m_used + 1 > wo) ? wo : m_used + 1;
        else begin m_owner = g; m_used = 1; end
        if (g == 0) m_cnt0 = (m_cnt0 + 1) % 65536;
        else        m_cnt1 = (m_cnt1 + 1) % 65536;
      end else if (out_a) begin
        m_out_v = 1'b0;
      end
      if (cnt_clear) begin m_cnt0 = 0; m_cnt1 = 0; end
    end
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; in0_v = 1'b1; in1_v = 1'b1; in0_d = 32'h0000_AAAA; in1_d = 32'h0000_BBBB;
    out_a = 1'b1; weight0 = 4'd4; weight1 = 4'd4; cnt_clear = 1'b0;
    m_out_v = 1'b0; m_owner = 0; m_used = 0; m_cnt0 = 0; m_cnt1 = 0;
    @(negedge clk);

    // Reset held with both inputs valid.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_out_v", 32'(s_ov), 32'd0);
      chk("rst_out_d", s_od, 32'd0);
      chk("rst_a0", 32'(s_a0), 32'd0);
      chk("rst_a1", 32'(s_a1), 32'd0);
      chk("rst_cnt0", 32'(cnt0), 32'd0);
      chk("rst_cnt1", 32'(cnt1), 32'd0);
    end
    reset = 1'b1;
    step();
    chk("first_grant_a0", 32'(s_a0), 32'd1);
    chk("first_grant_a1", 32'(s_a1), 32'd0);

    // Vector table, starting from reset state.
    tbl[0]  = '{1'b1, 1'b1, 4'd2, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'd2, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 4'd2, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 4'd2, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 4'd2, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 4'd2, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 4'd2, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 4'd2, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 4'd2, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 4'd2, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1};
    reset_pulse();
    for (int i = 0; i < 12; i++) begin
      in0_v = tbl[i].v0; in1_v = tbl[i].v1; weight0 = tbl[i].w0; weight1 = tbl[i].w1;
      out_a = tbl[i].oa;
      step();
      chk($sformatf("tbl%0d_a0", i), 32'(s_a0), 32'(tbl[i].ea0));
      chk($sformatf("tbl%0d_a1", i), 32'(s_a1), 32'(tbl[i].ea1));
      chk($sformatf("tbl%0d_ov", i), 32'(s_ov), 32'(tbl[i].eov));
    end

    // Weights 3/1, both saturated: 0,0,0,1 repeating.
    reset_pulse();
    weight0 = 4'd3; weight1 = 4'd1; in0_v = 1'b1; in1_v = 1'b1; out_a = 1'b1;
    in0_d = 32'h1000_0000; in1_d = 32'h2000_0000;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("wrr_seq%0d", i), 32'(s_a1), 32'((i % 4) == 3));
      chk($sformatf("wrr_seq%0d_a0", i), 32'(s_a0), 32'((i % 4) != 3));
      if (s_a0) in0_d = in0_d + 32'd1;
      if (s_a1) in1_d = in1_d + 32'd1;
    end
    chk("wrr_cnt0", 32'(cnt0), 32'd12);
    chk("wrr_cnt1", 32'(cnt1), 32'd4);

    // Output stalled for 5 cycles.
    out_a = 1'b0;
    hold_d = out_d;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_d_hold", s_od, hold_d);
      chk("bp_a0", 32'(s_a0), 32'd0);
      chk("bp_a1", 32'(s_a1), 32'd0);
      chk("bp_cnt0", 32'(cnt0), 32'd12);
      chk("bp_cnt1", 32'(cnt1), 32'd4);
    end
    out_a = 1'b1;
    step();
    chk("bp_resume_src0", 32'(s_a0), 32'd1);
    in0_v = 1'b0;

    // Idle owner: source 1 alone, then source 0 joins.
    reset_pulse();
    weight0 = 4'd3; weight1 = 4'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_src1_stream", 32'(s_a1), 32'd1);
      in1_d = in1_d + 32'd1;
    end
    in0_v = 1'b1;
    step();
    chk("idle_handback_src0", 32'(s_a0), 32'd1);

    // Zero weights: strict alternation.
    weight0 = 4'd0; weight1 = 4'd0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("w0_alt%0d", i), 32'(s_a1), 32'((i % 2) == 0));
      if (s_a0) in0_d = in0_d + 32'd1;
      if (s_a1) in1_d = in1_d + 32'd1;
    end
    in1_v = 1'b0;

    // Counter clear on a transfer, then wrap.
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    chk("clr_on_xfer_a", 32'(cnt0), 32'd0);
    for (int i = 0; i < 65537; i++) begin
      step();
      in0_d = in0_d + 32'd1;
    end
    chk("cnt0_wrap", 32'(cnt0), 32'd1);
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    chk("clr_on_xfer_b", 32'(cnt0), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        weight0 = 4'($urandom_range(0, 15));
        weight1 = 4'($urandom_range(0, 15));
      end
      out_a     = ($urandom_range(0, 3) != 0);
      cnt_clear = ($urandom_range(0, 49) == 0);
      reset     = ($urandom_range(0, 299) != 0);
      step();
      if (!in0_v || s_a0) begin in0_v = ($urandom_range(0, 2) != 0); in0_d = $urandom; end
      if (!in1_v || s_a1) begin in1_v = ($urandom_range(0, 2) != 0); in1_d = $urandom; end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
